// File: rtl/rr_enq_arbiter.sv
// -----------------------------------------------------------------------------
// rr_enq_arbiter
//
// Round-robin arbiter that shares one queue enqueue port between N decoupled
// requesters. It sits directly in front of a queue: io_out_* connect to the
// queue's io_enq_* signals. With BEATS > 1, a requester that wins keeps the
// port for BEATS transfers before arbitration resumes (burst locking).
//
// Parameters
//   N      number of requesters (>= 2)
//   W      payload width in bits
//   BEATS  transfers per grant before re-arbitration (1 = no locking)
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   reset         synchronous, active-high
//   io_in_valid   [N]     per-requester valid
//   io_in_bits    [N*W]   requester i payload at [i*W +: W]
//   io_in_ready   [N]     per-requester ready (only the chosen one can be 1)
//   io_out_valid          to queue enq valid
//   io_out_bits   [W]     to queue enq bits
//   io_out_ready          from queue enq ready
//   io_chosen     [CW]    index currently presented on io_out
//   io_locked             burst lock active
// -----------------------------------------------------------------------------
module rr_enq_arbiter #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int BEATS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         io_in_valid,
    input  logic [N*W-1:0]       io_in_bits,
    output logic [N-1:0]         io_in_ready,
    output logic                 io_out_valid,
    output logic [W-1:0]         io_out_bits,
    input  logic                 io_out_ready,
    output logic [$clog2(N)-1:0] io_chosen,
    output logic                 io_locked
);

    localparam int CW = $clog2(N);
    localparam int BW = $clog2(BEATS + 1);

    logic [CW-1:0] lastGrant_q, lastGrant_d;
    logic          locked_q,    locked_d;
    logic [CW-1:0] lockIdx_q,   lockIdx_d;
    logic [BW-1:0] beatCnt_q,   beatCnt_d;

    logic [CW-1:0] rrChoice;
    logic [CW-1:0] chosen;
    logic          fire;

    // Round-robin search. Scanning from the top down lets the lowest
    // qualifying index overwrite any higher one, so upIdx ends up as the
    // lowest valid index above lastGrant_q and anyIdx as the lowest valid
    // index overall (0 when nothing is valid).
    logic [CW-1:0] upIdx;
    logic [CW-1:0] anyIdx;
    logic          upHit;

    always_comb begin
        upIdx  = '0;
        anyIdx = '0;
        upHit  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (io_in_valid[i]) begin
                anyIdx = CW'(i);
                if (i > int'(lastGrant_q)) begin
                    upIdx = CW'(i);
                    upHit = 1'b1;
                end
            end
        end
        rrChoice = upHit ? upIdx : anyIdx;
    end

    // A held lock overrides arbitration, even when the owner has dropped
    // valid; that is what keeps other requesters out mid-burst.
    always_comb begin
        chosen = locked_q ? lockIdx_q : rrChoice;
    end

    // Output steering. chosen depends only on state and io_in_valid, so
    // io_out_ready never reaches io_out_valid, io_out_bits or io_chosen.
    always_comb begin
        io_out_valid = 1'b0;
        io_out_bits  = '0;
        io_in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (chosen == CW'(i)) begin
                io_out_valid   = io_in_valid[i];
                io_out_bits    = io_in_bits[i*W +: W];
                io_in_ready[i] = io_out_ready;
            end
        end
    end

    assign fire      = io_out_valid & io_out_ready;
    assign io_chosen = chosen;
    assign io_locked = locked_q;

    // Next-state logic: nothing moves unless a transfer actually happens.
    // With BEATS == 1 the lock branch is compiled away and locked/beatCnt
    // stay at their reset values.
    always_comb begin
        lastGrant_d = lastGrant_q;
        locked_d    = locked_q;
        lockIdx_d   = lockIdx_q;
        beatCnt_d   = beatCnt_q;
        if (fire) begin
            lastGrant_d = chosen;
            if (BEATS > 1) begin
                if (!locked_q) begin
                    locked_d  = 1'b1;
                    lockIdx_d = chosen;
                    beatCnt_d = BW'(1);
                end else if (beatCnt_q == BW'(BEATS - 1)) begin
                    locked_d  = 1'b0;
                    beatCnt_d = '0;
                end else begin
                    beatCnt_d = beatCnt_q + BW'(1);
                end
            end
        end
    end

    // lastGrant resets to N-1 so the first search wraps to requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q <= CW'(N - 1);
            locked_q    <= 1'b0;
            lockIdx_q   <= '0;
            beatCnt_q   <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            locked_q    <= locked_d;
            lockIdx_q   <= lockIdx_d;
            beatCnt_q   <= beatCnt_d;
        end
    end

endmodule

// File: tb/tb_rr_enq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_enq_arbiter
//
// Self-checking bench for rr_enq_arbiter. Two instances share clock and
// reset: dutA with BEATS=1 (plain round robin) and dutB with BEATS=3
// (burst locking). Inputs are driven on the falling edge, outputs are
// compared 1 time unit later, and state advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_rr_enq_arbiter;

    logic clk;
    logic reset;

    logic [3:0]  aValid, bValid;
    logic [31:0] aBits, bBits;
    logic        aOutReady, bOutReady;
    logic [3:0]  aInReady, bInReady;
    logic        aOutValid, bOutValid;
    logic [7:0]  aOutBits, bOutBits;
    logic [1:0]  aChosen, bChosen;
    logic        aLocked, bLocked;

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] bits;
        logic        ready;
        logic [1:0]  expChosen;
        logic        expValid;
        logic [7:0]  expBits;
        logic [3:0]  expInReady;
        logic        expLocked;
    } vec_t;

    vec_t vecs[$];

    rr_enq_arbiter #(.N(4), .W(8), .BEATS(1)) dutA (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (aValid),
        .io_in_bits   (aBits),
        .io_in_ready  (aInReady),
        .io_out_valid (aOutValid),
        .io_out_bits  (aOutBits),
        .io_out_ready (aOutReady),
        .io_chosen    (aChosen),
        .io_locked    (aLocked)
    );

    rr_enq_arbiter #(.N(4), .W(8), .BEATS(3)) dutB (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (bValid),
        .io_in_bits   (bBits),
        .io_in_ready  (bInReady),
        .io_out_valid (bOutValid),
        .io_out_bits  (bOutBits),
        .io_out_ready (bOutReady),
        .io_chosen    (bChosen),
        .io_locked    (bLocked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0h required=%0h", name, field, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit useB, input logic [3:0] valid,
                                 input logic [31:0] bits, input logic ready);
        if (useB) begin
            bValid    = valid;
            bBits     = bits;
            bOutReady = ready;
        end else begin
            aValid    = valid;
            aBits     = bits;
            aOutReady = ready;
        end
    endtask

    task automatic checkOutput(input string name, input bit useB,
                               input logic [1:0] expChosen, input logic expValid,
                               input logic [7:0] expBits, input logic [3:0] expInReady,
                               input logic expLocked);
        if (useB) begin
            checkField(name, "chosen",  32'(bChosen),   32'(expChosen));
            checkField(name, "valid",   32'(bOutValid), 32'(expValid));
            checkField(name, "bits",    32'(bOutBits),  32'(expBits));
            checkField(name, "inReady", 32'(bInReady),  32'(expInReady));
            checkField(name, "locked",  32'(bLocked),   32'(expLocked));
        end else begin
            checkField(name, "chosen",  32'(aChosen),   32'(expChosen));
            checkField(name, "valid",   32'(aOutValid), 32'(expValid));
            checkField(name, "bits",    32'(aOutBits),  32'(expBits));
            checkField(name, "inReady", 32'(aInReady),  32'(expInReady));
            checkField(name, "locked",  32'(aLocked),   32'(expLocked));
        end
    endtask

    // Drive one cycle's inputs, compare before the rising edge, then let the
    // edge pass and return on the next falling edge.
    task automatic cycleCheck(input string name, input bit useB,
                              input logic [3:0] valid, input logic [31:0] bits,
                              input logic ready, input logic [1:0] expChosen,
                              input logic expValid, input logic [7:0] expBits,
                              input logic [3:0] expInReady, input logic expLocked);
        applyStimulus(useB, valid, bits, ready);
        #1;
        checkOutput(name, useB, expChosen, expValid, expBits, expInReady, expLocked);
        @(negedge clk);
    endtask

    // Called on a falling edge; one rising edge passes with reset high.
    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic void addVec(input logic [3:0] valid, input logic [31:0] bits,
                                   input logic ready, input logic [1:0] ch,
                                   input logic ov, input logic [7:0] ob,
                                   input logic [3:0] ir, input logic lk);
        vec_t v;
        v.valid      = valid;
        v.bits       = bits;
        v.ready      = ready;
        v.expChosen  = ch;
        v.expValid   = ov;
        v.expBits    = ob;
        v.expInReady = ir;
        v.expLocked  = lk;
        vecs.push_back(v);
    endfunction

    localparam logic [31:0] PAY = 32'h44332211;

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        aValid    = '0; aBits = PAY; aOutReady = 1'b0;
        bValid    = '0; bBits = PAY; bOutReady = 1'b0;

        // Plain round robin on dutA, starting from reset (lastGrant = 3).
        for (int k = 0; k < 8; k++)
            addVec(4'b1111, PAY, 1'b1, 2'(k % 4), 1'b1,
                   8'((k % 4 + 1) * 8'h11), 4'(1 << (k % 4)), 1'b0);
        for (int k = 0; k < 3; k++)
            addVec(4'b0100, 32'h00A50000, 1'b1, 2'd2, 1'b1, 8'hA5, 4'b0100, 1'b0);
        addVec(4'b0011, PAY, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 1'b0);
        addVec(4'b0011, PAY, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 1'b0);
        addVec(4'b1001, PAY, 1'b1, 2'd3, 1'b1, 8'h44, 4'b1000, 1'b0);
        addVec(4'b1001, PAY, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 1'b0);
        addVec(4'b0000, PAY, 1'b1, 2'd0, 1'b0, 8'h11, 4'b0001, 1'b0);
        addVec(4'b0000, PAY, 1'b0, 2'd0, 1'b0, 8'h11, 4'b0000, 1'b0);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        #1;
        checkOutput("resetA", 1'b0, 2'd0, 1'b0, 8'h11, 4'b0000, 1'b0);
        checkOutput("resetB", 1'b1, 2'd0, 1'b0, 8'h11, 4'b0000, 1'b0);
        @(negedge clk);

        for (int k = 0; k < vecs.size(); k++)
            cycleCheck($sformatf("vecA%0d", k), 1'b0, vecs[k].valid, vecs[k].bits,
                       vecs[k].ready, vecs[k].expChosen, vecs[k].expValid,
                       vecs[k].expBits, vecs[k].expInReady, vecs[k].expLocked);

        // Queue stall on dutA: chosen must hold at 0 with no ready.
        doReset();
        for (int c = 0; c < 5; c++)
            cycleCheck($sformatf("stall%0d", c), 1'b0, 4'b1111, PAY, 1'b0,
                       2'd0, 1'b1, 8'h11, 4'b0000, 1'b0);
        cycleCheck("stallRelease", 1'b0, 4'b1111, PAY, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 1'b0);
        cycleCheck("stallNext",    1'b0, 4'b1111, PAY, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 1'b0);
        aValid = '0; aOutReady = 1'b0;

        // Bursts of three on dutB with requesters 1 and 3.
        doReset();
        cycleCheck("burst1a", 1'b1, 4'b1010, PAY, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 1'b0);
        cycleCheck("burst1b", 1'b1, 4'b1010, PAY, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 1'b1);
        cycleCheck("burst1c", 1'b1, 4'b1010, PAY, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 1'b1);
        cycleCheck("burst3a", 1'b1, 4'b1010, PAY, 1'b1, 2'd3, 1'b1, 8'h44, 4'b1000, 1'b0);
        cycleCheck("burst3b", 1'b1, 4'b1010, PAY, 1'b1, 2'd3, 1'b1, 8'h44, 4'b1000, 1'b1);
        cycleCheck("burst3c", 1'b1, 4'b1010, PAY, 1'b1, 2'd3, 1'b1, 8'h44, 4'b1000, 1'b1);
        cycleCheck("burst1d", 1'b1, 4'b1010, PAY, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 1'b0);

        // Owner 1 drops valid mid-burst: port idles, requester 3 stays out.
        cycleCheck("gap0",    1'b1, 4'b1000, PAY, 1'b1, 2'd1, 1'b0, 8'h22, 4'b0010, 1'b1);
        cycleCheck("gap1",    1'b1, 4'b1000, PAY, 1'b1, 2'd1, 1'b0, 8'h22, 4'b0010, 1'b1);
        cycleCheck("resume2", 1'b1, 4'b1010, PAY, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 1'b1);
        cycleCheck("resume3", 1'b1, 4'b1010, PAY, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 1'b1);
        cycleCheck("after",   1'b1, 4'b1010, PAY, 1'b1, 2'd3, 1'b1, 8'h44, 4'b1000, 1'b0);

        // Reset after beat 2 of a burst abandons it.
        doReset();
        cycleCheck("rstBeat1", 1'b1, 4'b1111, PAY, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 1'b0);
        cycleCheck("rstBeat2", 1'b1, 4'b1111, PAY, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 1'b1);
        doReset();
        cycleCheck("postRst",  1'b1, 4'b1111, PAY, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 1'b0);
        cycleCheck("newBurst", 1'b1, 4'b1111, PAY, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
